// File: rtl/ccg_tt_capture_if.sv
// Bus between ccg_tt_capture and its surroundings: benchmark drive/sample lines plus the result handshake.
// master = controller/benchmark side, slave = ccg_tt_capture.
interface ccg_tt_capture_if #(
    parameter int N_OUT = 16
);
    logic                 start;
    logic                 abort;
    logic                 x0;
    logic                 x1;
    logic [N_OUT-1:0]     f;
    logic                 busy;
    logic [4*N_OUT-1:0]   tt;
    logic                 tt_valid;
    logic                 tt_ready;
    logic [15:0]          sig;

    modport master (
        output start, abort, f, tt_ready,
        input  x0, x1, busy, tt, tt_valid, sig
    );

    modport slave (
        input  start, abort, f, tt_ready,
        output x0, x1, busy, tt, tt_valid, sig
    );
endinterface

// File: rtl/ccg_tt_capture.sv
// Sweeps a 2-input benchmark through its four minterms and harvests a 4*N_OUT-bit truth table.
// Optional 16-bit MISR signature enabled by defining CCG_TT_MISR_EN; otherwise sig is tied to zero.
module ccg_tt_capture #(
    parameter int N_OUT  = 16,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ccg_tt_capture_if.slave bus
);
    typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [1:0]           m_q, m_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           x_q, x_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [4*N_OUT-1:0]   tt_q, tt_d;
    logic                 in_sweep;
    logic                 abort_hit;

    assign in_sweep  = (state_q == APPLY) || (state_q == WAIT) || (state_q == SAMPLE);
    assign abort_hit = bus.abort && in_sweep;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        tt_d    = tt_q;
        // Abort outranks every sweep action, including the SAMPLE write.
        if (abort_hit) begin
            state_d = IDLE;
            m_d     = '0;
            cnt_d   = '0;
            x_d     = '0;
            busy_d  = 1'b0;
            tt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = APPLY;
                        m_d     = '0;
                        tt_d    = '0;
                        busy_d  = 1'b1;
                    end
                end
                APPLY: begin
                    x_d     = m_q;
                    cnt_d   = 4'(SETTLE);
                    state_d = (SETTLE > 0) ? WAIT : SAMPLE;
                end
                WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        tt_d[4*k + int'(m_q)] = bus.f[k];
                    end
                    if (m_q == 2'd3) begin
                        state_d = HOLD;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        m_d     = m_q + 2'd1;
                        state_d = APPLY;
                    end
                end
                HOLD: begin
                    if (bus.tt_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        x_d     = '0;
                        m_d     = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            tt_q    <= tt_d;
        end
    end

    assign bus.x0       = x_q[0];
    assign bus.x1       = x_q[1];
    assign bus.busy     = busy_q;
    assign bus.tt_valid = valid_q;
    assign bus.tt       = tt_q;

`ifdef CCG_TT_MISR_EN
    logic [15:0] sig_q, sig_d, f_pad;

    // f is zero-extended or truncated to the 16-bit MISR width.
    if (N_OUT >= 16) begin : g_trunc
        assign f_pad = bus.f[15:0];
    end else begin : g_pad
        assign f_pad = {{(16-N_OUT){1'b0}}, bus.f};
    end

    always_comb begin
        sig_d = sig_q;
        if (abort_hit) begin
            sig_d = '0;
        end else if (state_q == IDLE && bus.start) begin
            sig_d = 16'hFFFF;
        end else if (state_q == SAMPLE) begin
            sig_d = ({sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h100B : 16'h0000)) ^ f_pad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign bus.sig = sig_q;
`else
    assign bus.sig = 16'h0000;
`endif
endmodule

// File: tb/tb_ccg_tt_capture.sv
// Directed self-checking bench for ccg_tt_capture against a modelled 2-input/16-output reference benchmark.
// Also follows CCG_TT_MISR_EN so the sig expectations match the build under test.
module tb_ccg_tt_capture;
    // Reference benchmark: nibble k is f(k+1) over minterms {x1,x0}=3..0 (f2=x0|x1, f6=0, f8=1, f15=x1).
    localparam logic [63:0] REF_TT = 64'h2C4DB359_F70A16E8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fZero = 1'b0;
    logic auxStart = 1'b0;
    logic auxReady = 1'b0;
    int   testsRun  = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] benchF(input logic [63:0] table_, input logic [1:0] mt, input logic zero);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[k] = zero ? 1'b0 : table_[4*k + int'(mt)];
        end
        return r;
    endfunction

    function automatic logic [15:0] misrModel(input logic zero);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int m = 0; m < 4; m++) begin
            s = ({s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000)) ^ benchF(REF_TT, 2'(m), zero);
        end
        return s;
    endfunction

    ccg_tt_capture_if #(.N_OUT(16)) bus1 ();
    ccg_tt_capture_if #(.N_OUT(16)) busS0 ();
    ccg_tt_capture_if #(.N_OUT(16)) busS15 ();

    ccg_tt_capture #(.N_OUT(16), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    ccg_tt_capture #(.N_OUT(16), .SETTLE(0)) dutS0 (
        .clk(clk), .rst_n(rst_n), .bus(busS0)
    );
    ccg_tt_capture #(.N_OUT(16), .SETTLE(15)) dutS15 (
        .clk(clk), .rst_n(rst_n), .bus(busS15)
    );

    assign bus1.f   = benchF(REF_TT, {bus1.x1, bus1.x0}, fZero);
    assign busS0.f  = benchF(REF_TT, {busS0.x1, busS0.x0}, 1'b0);
    assign busS15.f = benchF(REF_TT, {busS15.x1, busS15.x0}, 1'b0);

    assign busS0.start     = auxStart;
    assign busS0.abort     = 1'b0;
    assign busS0.tt_ready  = auxReady;
    assign busS15.start    = auxStart;
    assign busS15.abort    = 1'b0;
    assign busS15.tt_ready = auxReady;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic startV, input logic abortV, input logic readyV);
        bus1.start    = startV;
        bus1.abort    = abortV;
        bus1.tt_ready = readyV;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string tag, input int limit);
        int n;
        n = 0;
        while (bus1.tt_valid !== 1'b1 && n < limit) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, 64'(bus1.tt_valid), 64'd1);
    endtask

    task automatic acceptResult(input string tag);
        applyStimulus(1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput(tag, 64'(bus1.tt_valid), 64'd0);
    endtask

    initial begin
        logic [15:0] expRefSig;
        logic [15:0] expZeroSig;
        logic        sawValid;
`ifdef CCG_TT_MISR_EN
        expRefSig  = misrModel(1'b0);
        expZeroSig = 16'h0F99;
`else
        expRefSig  = 16'h0000;
        expZeroSig = 16'h0000;
`endif
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Power-on reset values.
        #1;
        checkOutput("rst_x", 64'({bus1.x1, bus1.x0}), 64'd0);
        checkOutput("rst_busy", 64'(bus1.busy), 64'd0);
        checkOutput("rst_valid", 64'(bus1.tt_valid), 64'd0);
        checkOutput("rst_tt", bus1.tt, 64'd0);
        checkOutput("rst_sig", 64'(bus1.sig), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nextCycle();
        checkOutput("idle_busy", 64'(bus1.busy), 64'd0);

        // Full sweep, SETTLE=1: x sequence, busy window, tt_valid at cycle 13.
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            int em;
            em = (c < 2) ? 0 : (c - 2) / 3;
            if (em > 3) em = 3;
            checkOutput($sformatf("sweep_x_c%0d", c), 64'({bus1.x1, bus1.x0}), 64'(em));
            checkOutput($sformatf("sweep_busy_c%0d", c), 64'(bus1.busy), 64'd1);
            checkOutput($sformatf("sweep_valid_c%0d", c), 64'(bus1.tt_valid), 64'd0);
            nextCycle();
        end
        checkOutput("c13_valid", 64'(bus1.tt_valid), 64'd1);
        checkOutput("c13_busy", 64'(bus1.busy), 64'd0);
        checkOutput("c13_x", 64'({bus1.x1, bus1.x0}), 64'd3);
        checkOutput("c13_tt", bus1.tt, REF_TT);
        checkOutput("tt_f2", 64'(bus1.tt[7:4]), 64'b1110);
        checkOutput("tt_f15", 64'(bus1.tt[59:56]), 64'b1100);
        checkOutput("tt_f8", 64'(bus1.tt[31:28]), 64'b1111);
        checkOutput("tt_f6", 64'(bus1.tt[23:20]), 64'b0000);
        checkOutput("c13_sig", 64'(bus1.sig), 64'(expRefSig));

        // Back-pressure: 20 cycles without tt_ready, start pulses must be ignored.
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i % 2) == 0, 1'b0, 1'b0);
            nextCycle();
            checkOutput($sformatf("hold_valid_%0d", i), 64'(bus1.tt_valid), 64'd1);
            checkOutput($sformatf("hold_tt_%0d", i), bus1.tt, REF_TT);
            checkOutput($sformatf("hold_busy_%0d", i), 64'(bus1.busy), 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        nextCycle();
        checkOutput("accept_valid", 64'(bus1.tt_valid), 64'd0);
        checkOutput("accept_start_ignored", 64'(bus1.busy), 64'd0);
        checkOutput("accept_tt_kept", bus1.tt, REF_TT);
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_busy", 64'(bus1.busy), 64'd1);
        checkOutput("restart_tt_clear", bus1.tt, 64'd0);
        waitValid("restart_done", 20);
        checkOutput("restart_tt", bus1.tt, REF_TT);
        acceptResult("restart_accept");

        // Abort during the minterm-2 SAMPLE cycle (cycle 9).
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (8) nextCycle();
        checkOutput("abort_pre_x", 64'({bus1.x1, bus1.x0}), 64'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_busy", 64'(bus1.busy), 64'd0);
        checkOutput("abort_tt", bus1.tt, 64'd0);
        checkOutput("abort_x", 64'({bus1.x1, bus1.x0}), 64'd0);
        checkOutput("abort_sig", 64'(bus1.sig), 64'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus1.tt_valid !== 1'b0) sawValid = 1'b1;
            nextCycle();
        end
        checkOutput("abort_no_valid", 64'(sawValid), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitValid("post_abort_done", 20);
        checkOutput("post_abort_tt", bus1.tt, REF_TT);
        checkOutput("post_abort_sig", 64'(bus1.sig), 64'(expRefSig));
        acceptResult("post_abort_accept");

        // Asynchronous reset during the minterm-1 WAIT cycle (cycle 5).
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) nextCycle();
        checkOutput("rstmid_pre_x", 64'({bus1.x1, bus1.x0}), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_x", 64'({bus1.x1, bus1.x0}), 64'd0);
        checkOutput("rstmid_busy", 64'(bus1.busy), 64'd0);
        checkOutput("rstmid_valid", 64'(bus1.tt_valid), 64'd0);
        checkOutput("rstmid_tt", bus1.tt, 64'd0);
        checkOutput("rstmid_sig", 64'(bus1.sig), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            if (bus1.busy !== 1'b0 || bus1.tt_valid !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("rstmid_idle", 64'(sawValid), 64'd0);

        // Constant-zero benchmark outputs: MISR after four updates from the seed.
        fZero = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitValid("zero_done", 20);
        checkOutput("zero_tt", bus1.tt, 64'd0);
        checkOutput("zero_sig", 64'(bus1.sig), 64'(expZeroSig));
        acceptResult("zero_accept");
        fZero = 1'b0;

        // SETTLE=0 and SETTLE=15 instances: tt_valid at cycles 9 and 69.
        auxStart = 1'b1;
        nextCycle();
        auxStart = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            if (c == 2) checkOutput("s0_x_c2", 64'({busS0.x1, busS0.x0}), 64'd0);
            if (c == 4) checkOutput("s0_x_c4", 64'({busS0.x1, busS0.x0}), 64'd1);
            if (c == 8) checkOutput("s0_valid_c8", 64'(busS0.tt_valid), 64'd0);
            if (c == 9) begin
                checkOutput("s0_valid_c9", 64'(busS0.tt_valid), 64'd1);
                checkOutput("s0_tt", busS0.tt, REF_TT);
            end
            if (c == 19) checkOutput("s15_x_c19", 64'({busS15.x1, busS15.x0}), 64'd1);
            if (c == 68) checkOutput("s15_valid_c68", 64'(busS15.tt_valid), 64'd0);
            if (c == 69) begin
                checkOutput("s15_valid_c69", 64'(busS15.tt_valid), 64'd1);
                checkOutput("s15_tt", busS15.tt, REF_TT);
            end
            if (c < 69) nextCycle();
        end
        auxReady = 1'b1;
        nextCycle();
        auxReady = 1'b0;
        checkOutput("s0_accept", 64'(busS0.tt_valid), 64'd0);
        checkOutput("s15_accept", 64'(busS15.tt_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
